// File: rtl/smm_resp_pkg.sv
// Shared constants for the smm register responder: register offsets,
// CTRL bit positions, irq handshake state encoding and a byte-mask helper.
package smm_resp_pkg;

    localparam logic [4:0] OFS_ID       = 5'h00;
    localparam logic [4:0] OFS_SCRATCH  = 5'h04;
    localparam logic [4:0] OFS_CTRL     = 5'h08;
    localparam logic [4:0] OFS_STATUS   = 5'h0C;
    localparam logic [4:0] OFS_MASK     = 5'h10;
    localparam logic [4:0] OFS_COUNT    = 5'h14;
    localparam logic [4:0] OFS_TIME     = 5'h18;
    localparam logic [4:0] OFS_IRQ_TIME = 5'h1C;

    localparam int CTRL_IRQ_EN    = 0;
    localparam int CTRL_COUNT_CLR = 1;

    typedef enum logic [1:0] {
        IRQ_IDLE     = 2'd0,
        IRQ_ASSERT   = 2'd1,
        IRQ_WAIT_REL = 2'd2
    } irq_state_t;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/smm_reg_responder_if.sv
// Memory-mapped bus between the smm controller (master) and a responder.
// No wait signal: read data is expected exactly one cycle after CS.
interface smm_reg_responder_if;

    logic        CS;
    logic        RNW;
    logic [15:0] ADDR;
    logic [3:0]  BE;
    logic [31:0] WR_DATA;
    logic [31:0] RD_DATA;

    modport master (
        output CS, RNW, ADDR, BE, WR_DATA,
        input  RD_DATA
    );

    modport slave (
        input  CS, RNW, ADDR, BE, WR_DATA,
        output RD_DATA
    );

endinterface

// File: rtl/smm_irq_handshake.sv
// Four-phase INTERRUPT / INTERRUPT_ACK handshake toward the smm controller.
// assert_pulse is high for the first cycle of every IDLE->ASSERT request.
import smm_resp_pkg::*;

module smm_irq_handshake (
    input  logic CLK,
    input  logic RESET,
    input  logic pending,
    input  logic INTERRUPT_ACK,
    output logic INTERRUPT,
    output logic assert_pulse
);

    irq_state_t state;

    // Request/acknowledge state machine with registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IRQ_IDLE;
            INTERRUPT    <= 1'b0;
            assert_pulse <= 1'b0;
        end else begin
            assert_pulse <= 1'b0;
            case (state)
                IRQ_IDLE: begin
                    if (pending) begin
                        state        <= IRQ_ASSERT;
                        INTERRUPT    <= 1'b1;
                        assert_pulse <= 1'b1;
                    end
                end
                IRQ_ASSERT: begin
                    if (INTERRUPT_ACK) begin
                        state     <= IRQ_WAIT_REL;
                        INTERRUPT <= 1'b0;
                    end else if (!pending) begin
                        state     <= IRQ_IDLE;
                        INTERRUPT <= 1'b0;
                    end
                end
                IRQ_WAIT_REL: begin
                    if (!INTERRUPT_ACK) begin
                        state <= IRQ_IDLE;
                    end
                end
                default: begin
                    state     <= IRQ_IDLE;
                    INTERRUPT <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/smm_reg_responder.sv
// Register bank responder on the smm bus with sticky event status and irq.
// Define SMM_RESP_TIMESTAMP_EN to add the TIME / IRQ_TIME registers.
import smm_resp_pkg::*;

module smm_reg_responder #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [31:0] ID_VALUE  = 32'h534D_0001,
    parameter int          EVT_W     = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    smm_reg_responder_if.slave bus,
    input  logic [EVT_W-1:0] EVENT,
    output logic             INTERRUPT,
    input  logic             INTERRUPT_ACK
);

    logic        hit;
    logic        wr;
    logic        rd;
    logic [4:0]  ofs;
    logic [31:0] wmask;
    logic [31:0] wbits;
    logic [31:0] evt_ext;
    logic        count_clr;
    logic        pending;
    logic        assert_pulse;
    logic [31:0] rd_mux;

    logic [31:0] scratch;
    logic        irq_en;
    logic [31:0] status;
    logic [31:0] mask;
    logic [31:0] count;

    assign hit   = bus.CS && (bus.ADDR[15:5] == BASE_ADDR[15:5]);
    assign wr    = hit && !bus.RNW;
    assign rd    = hit && bus.RNW;
    assign ofs   = {bus.ADDR[4:2], 2'b00};
    assign wmask = be_mask(bus.BE);
    assign wbits = bus.WR_DATA & wmask;

    assign count_clr = wr && (ofs == OFS_CTRL) && bus.BE[0]
                       && bus.WR_DATA[CTRL_COUNT_CLR];

    assign pending = irq_en && |(status & mask);

    // Zero-extend event lines to the register width
    always_comb begin
        evt_ext = '0;
        evt_ext[EVT_W-1:0] = EVENT;
    end

    // Register writes; event set beats a same-cycle W1C on STATUS
    always_ff @(posedge CLK) begin
        if (RESET) begin
            scratch <= '0;
            irq_en  <= 1'b0;
            status  <= '0;
            mask    <= '0;
        end else begin
            if (wr && ofs == OFS_SCRATCH)
                scratch <= (scratch & ~wmask) | wbits;
            if (wr && ofs == OFS_CTRL && bus.BE[0])
                irq_en <= bus.WR_DATA[CTRL_IRQ_EN];
            if (wr && ofs == OFS_MASK)
                mask <= (mask & ~wmask) | wbits;
            if (wr && ofs == OFS_STATUS)
                status <= (status & ~wbits) | evt_ext;
            else
                status <= status | evt_ext;
        end
    end

    // Event counter: one per cycle with any event, clear wins
    always_ff @(posedge CLK) begin
        if (RESET)
            count <= '0;
        else if (count_clr)
            count <= '0;
        else if (|EVENT)
            count <= count + 32'd1;
    end

`ifdef SMM_RESP_TIMESTAMP_EN
    logic [31:0] time_cnt;
    logic [31:0] irq_time;

    // Free-running cycle counter and capture on each new interrupt request
    always_ff @(posedge CLK) begin
        if (RESET) begin
            time_cnt <= '0;
            irq_time <= '0;
        end else begin
            time_cnt <= time_cnt + 32'd1;
            if (assert_pulse)
                irq_time <= time_cnt;
        end
    end
`else
    logic unused_pulse;
    assign unused_pulse = assert_pulse;
`endif

    // Read mux reflects register state before this cycle's updates
    always_comb begin
        rd_mux = '0;
        case (ofs)
            OFS_ID:       rd_mux = ID_VALUE;
            OFS_SCRATCH:  rd_mux = scratch;
            OFS_CTRL:     rd_mux = {31'd0, irq_en};
            OFS_STATUS:   rd_mux = status;
            OFS_MASK:     rd_mux = mask;
            OFS_COUNT:    rd_mux = count;
`ifdef SMM_RESP_TIMESTAMP_EN
            OFS_TIME:     rd_mux = time_cnt;
            OFS_IRQ_TIME: rd_mux = irq_time;
`endif
            default:      rd_mux = '0;
        endcase
    end

    // Read data register, updated only on read hits
    always_ff @(posedge CLK) begin
        if (RESET)
            bus.RD_DATA <= '0;
        else if (rd)
            bus.RD_DATA <= rd_mux;
    end

    logic unused_addr;
    assign unused_addr = ^bus.ADDR[1:0];

    smm_irq_handshake u_irq (
        .CLK           (CLK),
        .RESET         (RESET),
        .pending       (pending),
        .INTERRUPT_ACK (INTERRUPT_ACK),
        .INTERRUPT     (INTERRUPT),
        .assert_pulse  (assert_pulse)
    );

endmodule

// File: tb/tb_smm_reg_responder.sv
// Directed plus randomized bench for smm_reg_responder against a
// register-level reference model of the bus-visible behaviour.
module tb_smm_reg_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] event_in = '0;
    logic       ack = 1'b0;
    logic       intr;

    smm_reg_responder_if bus();

    smm_reg_responder dut (
        .CLK           (clk),
        .RESET         (rst),
        .bus           (bus),
        .EVENT         (event_in),
        .INTERRUPT     (intr),
        .INTERRUPT_ACK (ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_scratch, m_status, m_mask, m_count, m_rd;
    logic        m_irq_en;
    logic        m_pend;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] ofs);
        case (ofs)
            16'h00:  return 32'h534D_0001;
            16'h04:  return m_scratch;
            16'h08:  return {31'd0, m_irq_en};
            16'h0C:  return m_status;
            16'h10:  return m_mask;
            16'h14:  return m_count;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_scratch = 0; m_status = 0; m_mask = 0; m_count = 0;
        m_rd = 0; m_irq_en = 0; m_pend = 0;
    endtask

    // One bus cycle: drive inputs, advance the model, then the clock
    task automatic step(input logic cs, input logic rnw,
                        input logic [15:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [7:0] evt,
                        input logic a);
        logic        hit, clr, pend;
        logic [15:0] ofs;
        logic [31:0] bm;
        bus.CS = cs; bus.RNW = rnw; bus.ADDR = addr;
        bus.BE = be; bus.WR_DATA = wd;
        event_in = evt; ack = a;
        pend = m_irq_en && ((m_status & m_mask) != 0);
        hit = cs && (addr < 16'h0020);
        ofs = addr & 16'h001C;
        clr = 0;
        bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (hit && rnw) m_rd = model_read(ofs);
        if (hit && !rnw) begin
            case (ofs)
                16'h04: m_scratch = (m_scratch & ~bm) | (wd & bm);
                16'h08: if (be[0]) begin m_irq_en = wd[0]; clr = wd[1]; end
                16'h0C: m_status = m_status & ~(wd & bm);
                16'h10: m_mask = (m_mask & ~bm) | (wd & bm);
                default: ;
            endcase
        end
        m_status = m_status | {24'd0, evt};
        if (clr) m_count = 0;
        else if (evt != 0) m_count = m_count + 1;
        @(posedge clk); #1;
        m_pend = pend;
    endtask

    task automatic idle(input logic a);
        step(1'b0, 1'b1, 16'h0, 4'h0, 32'h0, 8'h0, a);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [3:0] be,
                      input logic [31:0] wd);
        step(1'b1, 1'b0, addr, be, wd, 8'h0, ack);
    endtask

    task automatic rd(input logic [15:0] addr);
        step(1'b1, 1'b1, addr, 4'h0, 32'h0, 8'h0, ack);
    endtask

    initial begin
        model_reset();
        bus.CS = 0; bus.RNW = 1; bus.ADDR = 0; bus.BE = 0; bus.WR_DATA = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", bus.RD_DATA, 32'h0);
        chk("reset_int", {31'd0, intr}, 32'h0);
        rst = 0;

        rd(16'h00); chk("rd_id", bus.RD_DATA, 32'h534D_0001);
        rd(16'h04); chk("rd_scratch0", bus.RD_DATA, 32'h0);
        rd(16'h14); chk("rd_count0", bus.RD_DATA, 32'h0);
        chk("int_idle", {31'd0, intr}, 32'h0);

        wr(16'h04, 4'b0101, 32'hAABB_CCDD);
        rd(16'h04); chk("scratch_be", bus.RD_DATA, 32'h00BB_00DD);
        wr(16'h04, 4'b0000, 32'hFFFF_FFFF);
        rd(16'h04); chk("scratch_be0", bus.RD_DATA, 32'h00BB_00DD);

        wr(16'h10, 4'hF, 32'h1);
        wr(16'h08, 4'hF, 32'h1);
        step(1'b0, 1'b1, 16'h0, 4'h0, 32'h0, 8'h01, 1'b0);
        chk("int_lat1", {31'd0, intr}, 32'h0);
        idle(1'b0);
        chk("int_lat2", {31'd0, intr}, 32'h1);
        rd(16'h0C); chk("status_evt", bus.RD_DATA, 32'h1);
        rd(16'h14); chk("count_evt", bus.RD_DATA, 32'h1);
        chk("int_held", {31'd0, intr}, 32'h1);

        idle(1'b1);
        chk("int_ack", {31'd0, intr}, 32'h0);
        wr(16'h0C, 4'hF, 32'h1);
        idle(1'b0);
        idle(1'b0);
        chk("int_cleared", {31'd0, intr}, 32'h0);

        step(1'b0, 1'b1, 16'h0, 4'h0, 32'h0, 8'h01, 1'b0);
        idle(1'b0);
        chk("int_again", {31'd0, intr}, 32'h1);
        idle(1'b1);
        idle(1'b0);
        chk("int_rel", {31'd0, intr}, 32'h0);
        idle(1'b0);
        chk("int_reassert", {31'd0, intr}, 32'h1);
        idle(1'b1);
        wr(16'h0C, 4'hF, 32'h1);
        idle(1'b0);
        idle(1'b0);
        chk("int_done", {31'd0, intr}, 32'h0);

        step(1'b1, 1'b0, 16'h0C, 4'hF, 32'h08, 8'h08, 1'b0);
        rd(16'h0C); chk("set_beats_clr", bus.RD_DATA, m_status);
        chk("status_bit3", {31'd0, bus.RD_DATA[3]}, 32'h1);

        step(1'b1, 1'b0, 16'h08, 4'h1, 32'h3, 8'h04, 1'b0);
        rd(16'h14); chk("count_clr", bus.RD_DATA, 32'h0);
        rd(16'h08); chk("ctrl_rd", bus.RD_DATA, 32'h1);

        force dut.count = 32'hFFFF_FFFF;
        #1;
        release dut.count;
        m_count = 32'hFFFF_FFFF;
        step(1'b0, 1'b1, 16'h0, 4'h0, 32'h0, 8'h02, 1'b0);
        rd(16'h14); chk("count_wrap", bus.RD_DATA, 32'h0);

`ifndef SMM_RESP_TIMESTAMP_EN
        rd(16'h18); chk("unmapped18", bus.RD_DATA, 32'h0);
`endif
        rd(16'h04);
        rd(16'h0104); chk("off_window_rd", bus.RD_DATA, 32'h00BB_00DD);
        wr(16'h0104, 4'hF, 32'h1234_5678);
        rd(16'h04); chk("off_window_wr", bus.RD_DATA, 32'h00BB_00DD);

        for (int i = 0; i < 300; i++) begin
            logic        cs, rnw;
            logic [15:0] addr;
            logic [7:0]  evt;
            cs = ($urandom % 4) != 0;
            rnw = $urandom % 2;
            addr = 16'($urandom % 8) * 16'd4;
            if (($urandom % 8) == 0) addr = addr + 16'h0100;
`ifdef SMM_RESP_TIMESTAMP_EN
            if (addr[4:0] >= 5'h18) rnw = 1'b0;
`endif
            evt = (($urandom % 4) == 0) ? 8'($urandom) : 8'h0;
            step(cs, rnw, addr, 4'($urandom), $urandom, evt, 1'b0);
            chk("rand_rd", bus.RD_DATA, m_rd);
            chk("rand_int", {31'd0, intr}, {31'd0, m_pend});
        end

        rst = 1; idle(1'b0); rst = 0;
        model_reset();
        wr(16'h08, 4'hF, 32'h1);
        wr(16'h10, 4'hF, 32'hFF);
        step(1'b0, 1'b1, 16'h0, 4'h0, 32'h0, 8'h01, 1'b0);
        idle(1'b0);
        chk("pre_rst_int", {31'd0, intr}, 32'h1);
        rd(16'h0C);
        rst = 1;
        idle(1'b1);
        chk("rst_int", {31'd0, intr}, 32'h0);
        chk("rst_rd", bus.RD_DATA, 32'h0);
        rst = 0;
        model_reset();
        idle(1'b1);
        chk("rst_ack_ign", {31'd0, intr}, 32'h0);
        for (int a = 0; a < 6; a++) begin
            rd(16'(a * 4));
            chk("rst_reg", bus.RD_DATA, m_rd);
        end
        chk("rst_int_end", {31'd0, intr}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smm_reg_responder.md
Name: smm_reg_responder

Overview:
- Bus responder (slave) for the smm controller's memory-mapped bus, sitting on the other end of CS/RNW/ADDR/BE/data.
- Provides a small register bank: ID, scratch, control, interrupt status/mask and an event counter.
- Collects 8 sticky hardware event lines and drives the smm INTERRUPT input, using a four-phase INTERRUPT/INTERRUPT_ACK handshake.
- The bus has no wait signal, so read latency is fixed.

Parameters:
BASE_ADDR, 16'h0000, window base; decode ADDR[15:5]==BASE_ADDR[15:5]
ID_VALUE, 32'h534D_0001, value returned by ID register
EVT_W, 8, number of event inputs (1..32)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
CS  in  1  bus cycle strobe from master, one cycle per access
RNW  in  1  1=read, 0=write; qualified by CS
ADDR  in  16  byte address; ADDR[1:0] ignored
BE  in  4  byte enables for writes; BE[0]=bits 7:0
WR_DATA  in  32  write data (master DOUT)
RD_DATA  out  32  read data (master DIN)
EVENT  in  EVT_W  single-cycle event pulses
INTERRUPT  out  1  interrupt request to master
INTERRUPT_ACK  in  1  acknowledge from master

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RESET). Reset wins over every other event in the same cycle.
- Reset values: RD_DATA=0, INTERRUPT=0, SCRATCH=0, CTRL=0, STATUS=0, MASK=0, COUNT=0, irq FSM=IDLE.
- Hit = CS & window match. Register index = ADDR[4:2].
- Register map (byte offsets):
  - 0x00 ID: RO.
  - 0x04 SCRATCH: RW, byte-enabled.
  - 0x08 CTRL: bit0 IRQ_EN, bit1 COUNT_CLR (self-clearing; reads 0). Other bits RO 0.
  - 0x0C STATUS: W1C, byte-enabled.
  - 0x10 MASK: RW, byte-enabled.
  - 0x14 COUNT: RO.
  - 0x18/0x1C: see optional feature.
  - Unmapped offsets read 0; writes to them are ignored.
- Writes: take effect at the clock edge of the CS cycle. BE gates each byte independently. BE=0000 is a no-op.
- Reads: RD_DATA is registered and valid on the cycle after CS&RNW (latency 1). It holds until the next read hit. Non-hit cycles do not change RD_DATA.
- Read snapshot: a read returns register state before any same-cycle update.
- STATUS: bit i sets when EVENT[i]=1. If a set and a W1C clear hit the same bit in the same cycle, set wins. Bits at or above EVT_W read 0.
- COUNT: +1 per cycle in which any EVENT bit is high (not per bit). Wraps 0xFFFF_FFFF->0. A COUNT_CLR write forces 0, and the clear beats a same-cycle increment.
- pending = IRQ_EN & |(STATUS & MASK).
- irq FSM:
  - IDLE: INTERRUPT=0. If pending, go to ASSERT.
  - ASSERT: INTERRUPT=1. If INTERRUPT_ACK=1, go to WAIT_REL. If pending drops first (e.g. IRQ_EN cleared), go to IDLE.
  - WAIT_REL: INTERRUPT=0. Stay until INTERRUPT_ACK=0, then go to IDLE; re-assert next cycle if still pending.
  - INTERRUPT is registered: it goes high 2 cycles after the EVENT edge (status cycle + FSM cycle).
  - INTERRUPT_ACK high while in IDLE is ignored.
- Reset mid-handshake: return to IDLE and drop INTERRUPT the next cycle, regardless of ACK.

Optional Feature:
SMM_RESP_TIMESTAMP_EN
- Defined:
  - 0x18 TIME: RO free-running 32-bit cycle counter, reset 0, wraps.
  - 0x1C IRQ_TIME: captures TIME on each IDLE->ASSERT transition; RO, reset 0.
- Undefined: no counter logic; 0x18/0x1C read 0 and are treated as unmapped.

Decomposition:
- Package smm_resp_pkg holds:
  - register offset constants (OFS_ID..OFS_IRQ_TIME)
  - CTRL bit positions
  - irq FSM state encoding (IDLE/ASSERT/WAIT_REL, 2-bit)
- One natural sub-module: smm_irq_handshake, containing the FSM only.
  - Inputs: CLK, RESET, pending, INTERRUPT_ACK.
  - Outputs: INTERRUPT, assert_pulse.
- The register bank stays in the top level.

Test Plan:
- Reset, then read 0x00/0x04/0x14 -> RD_DATA=0x534D0001, then 0, then 0, each one cycle after CS. INTERRUPT=0 throughout.
- Write 0x04 with data 0xAABBCCDD, BE=0101, then read -> 0x00BB00DD. Then write 0xFFFFFFFF with BE=0000 and read -> unchanged 0x00BB00DD.
- Set MASK=0x01 and CTRL=0x1, pulse EVENT=0x01 for one cycle -> INTERRUPT=1 two cycles later. STATUS reads 0x01. COUNT reads 1.
- Hold ACK=1 -> INTERRUPT drops next cycle. Write STATUS=0x01 (W1C), then release ACK -> stays 0. If STATUS is not cleared before ACK=0 -> INTERRUPT re-asserts 1 cycle after ACK falls.
- Pulse EVENT[3] in the same cycle as a W1C write of 0x08 to STATUS -> STATUS bit3 remains 1. Preload COUNT to wrap via 2^32 events (force) -> 0.
- Assert RESET while in ASSERT with ACK=1 -> INTERRUPT=0 the next cycle, and all registers read their reset values.
